pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel, parametrised PWM peripheral. It drives CHANNELS outputs from one shared period counter. Each channel has its own duty and polarity. Duty and period writes are double-buffered, so they take effect only at a period boundary, which prevents glitched or truncated pulses. The block sits on the memory-mapped peripheral write bus in place of single-channel PWM ports, and supports edge-aligned and centre-aligned modes.

## Interface
- CHANNELS, 4: number of PWM outputs (1..16).
- WIDTH, 16: counter, period and duty width in bits (2..32).
- ADDR_W, 5: register address width. Requires CHANNELS+2 <= 2^ADDR_W.

- clk  in  1  main clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  register write strobe, sampled on rising clk.
- wr_addr  in  ADDR_W  register address.
- wr_data  in  32  write data. Bits above WIDTH are ignored for period/duty.
- pwm_out  out  CHANNELS  registered PWM outputs.
- period_start  out  1  one-cycle pulse at the start of each period.

## Operation
- Register map:
  - addr 0 = PERIOD staging.
  - addr 1 = CTRL: bit0 EN, bit1 MODE (0 edge, 1 centre), bits[16+c] POL[c] (1 = active-low output).
  - addr 2+c = DUTY[c] staging.
  - Writes to unmapped addresses are ignored.
- CTRL is not shadowed; it applies on the clock after the write.
- PERIOD and DUTY have two copies each: staging (written by the bus) and active (used by the compare). All active copies load from staging together at a "load point":
  - every cycle while EN=0 or active PERIOD=0;
  - otherwise at each period boundary.
- Edge mode:
  - counter counts 0,1..P-1,0...
  - The boundary is the step from P-1 to 0.
- Centre mode:
  - counter counts up 0..P-1, holds direction change so P-1 repeats, counts down P-1..0, then 0 repeats going up.
  - Cycle length is 2P. The boundary is the step from down-0 to up-0.
- Raw compare per channel: raw[c] = (counter < duty_act[c]).
  - duty >= P gives 100%; duty=0 gives 0%.
  - Compare is unsigned, WIDTH bits.
- Output: pwm_out[c] <= raw[c] XOR POL[c].
- EN=0 or active P=0:
  - counter held at 0, direction up;
  - pwm_out[c] = POL[c] (inactive level);
  - period_start=0.
- period_start is registered: 1 during the cycle pwm_out reflects counter=0 at the start of a period (up-count 0 in centre mode).
- Simultaneous write and load point in the same cycle: the active copy takes the old staging value; the new value lands at the next load point.

## Timing
- Reset (async assert): all staging, active and CTRL registers = 0; counter=0; direction up; pwm_out=0; period_start=0. Deassertion is synchronised internally; the first count occurs on the second rising clk after release.
- Write latency: staging updates on the clk edge sampling wr_en. The active copy loads at the next load point. The output reflects it one cycle later.
- Output latency: pwm_out and period_start lag the counter by exactly 1 cycle.
- EN 0→1 at edge N:
  - counter=0 at N+1, so period_start=1 and pwm_out shows count 0 at N+2;
  - active values are those staged before edge N+1.
- EN 1→0: on the next edge, counter clears and outputs go to inactive level mid-period. No completion of the current pulse.
- Reset mid-period: outputs drop to 0 immediately (asynchronously), regardless of POL.
- Edge mode, P=1: duty>=1 gives constant active, duty=0 gives constant inactive; period_start is high every cycle.

## Test plan
- Reset, write P=10, DUTY0=3, DUTY1=7, EN=1 -> pwm_out[0] high exactly 3 of every 10 cycles and pwm_out[1] high 7 of 10. Both rise in the cycle period_start=1. period_start period is 10.
- Shadowing: mid-period (counter=4) write DUTY0=8 -> remainder of the current period still uses 3; the next period shows 8 high cycles. Same check with P changed from 10 to 6.
- Limits: DUTY0=0 -> constant 0; DUTY0=15 with P=10 -> constant 1. POL0=1 inverts both cases. EN=0 -> pwm_out[0]=POL0.
- Centre mode: P=8, DUTY0=3 -> period_start every 16 cycles; pwm_out[0] high 6 consecutive cycles, starting 3 cycles before period_start's cycle and ending 3 cycles after it inclusive (centred on the boundary).
- Async reset asserted mid-pulse -> pwm_out=0 within the same cycle without a clk edge. After release all registers read back as defaults: outputs stay 0 until reprogrammed.
- Write DUTY2 in the exact cycle of a boundary -> the old value is used for that period and the new value applies from the following period.

Source files
------------

// File: rtl/pwm_multi.sv
// pwm_multi: multi-channel PWM peripheral sharing one period counter.
//
// All channels share one period counter. Each channel has its own duty and
// polarity. PERIOD and DUTY are double-buffered: the bus writes a staging copy,
// and the compare uses an active copy. The active copy loads from staging at a
// load point. That is every cycle while disabled (or while the active period is
// 0), otherwise at the period boundary. CTRL applies directly. Edge-aligned and
// centre-aligned counting are supported.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset (release synchronised inside)
//   wr_en         register write strobe
//   wr_addr       register address: 0 PERIOD, 1 CTRL, 2+c DUTY[c]
//   wr_data       write data (period/duty use the low WIDTH bits)
//   pwm_out       registered PWM outputs, one per channel
//   period_start  registered one-cycle pulse at the start of every period
module pwm_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 16,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [31:0]         wr_data,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_start
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic                run_q;
    logic                en_q, en_d;
    logic                mode_q, mode_d;
    logic [CHANNELS-1:0] pol_q, pol_d;
    logic [WIDTH-1:0]    period_stg_q, period_stg_d;
    logic [WIDTH-1:0]    period_act_q, period_act_d;
    logic [WIDTH-1:0]    duty_stg_q [CHANNELS];
    logic [WIDTH-1:0]    duty_stg_d [CHANNELS];
    logic [WIDTH-1:0]    duty_act_q [CHANNELS];
    logic [WIDTH-1:0]    duty_act_d [CHANNELS];
    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;      // 1 = counting down (centre mode only)
    logic                idle_q, idle_d;    // counter parked; next enabled edge starts a period
    logic [CHANNELS-1:0] pwm_q, pwm_d;
    logic                ps_q, ps_d;
    logic                hold_s, active_s, load_s;
    logic [WIDTH-1:0]    last_s;
    logic [CHANNELS-1:0] raw_s;
    logic                unused_wr_data_s;

    // Not every wr_data bit is decoded by a register.
    assign unused_wr_data_s = ^wr_data;

    assign hold_s   = !en_q || (period_act_q == CNT_ZERO);
    assign active_s = !hold_s && !idle_q;
    assign last_s   = period_act_q - CNT_ONE;

    // Register bus decode into staging copies and CTRL.
    always_comb begin
        period_stg_d = period_stg_q;
        duty_stg_d   = duty_stg_q;
        en_d         = en_q;
        mode_d       = mode_q;
        pol_d        = pol_q;
        if (wr_en) begin
            if (wr_addr == ADDR_W'(0)) begin
                period_stg_d = wr_data[WIDTH-1:0];
            end else if (wr_addr == ADDR_W'(1)) begin
                en_d   = wr_data[0];
                mode_d = wr_data[1];
                pol_d  = wr_data[16 +: CHANNELS];
            end else begin
                for (int c = 0; c < CHANNELS; c++) begin
                    if (wr_addr == ADDR_W'(c + 2)) begin
                        duty_stg_d[c] = wr_data[WIDTH-1:0];
                    end else begin
                        duty_stg_d[c] = duty_stg_q[c];
                    end
                end
            end
        end else begin
            period_stg_d = period_stg_q;
        end
    end

    // Counter sequencing and load-point detection.
    always_comb begin
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        idle_d = idle_q;
        load_s = 1'b0;
        if (hold_s) begin
            cnt_d  = CNT_ZERO;
            dir_d  = 1'b0;
            idle_d = 1'b1;
            load_s = 1'b1;
        end else if (idle_q) begin
            // First enabled edge: enter count 0 of a fresh period with fresh values.
            cnt_d  = CNT_ZERO;
            dir_d  = 1'b0;
            idle_d = 1'b0;
            load_s = 1'b1;
        end else if (!mode_q) begin
            dir_d = 1'b0;
            if (cnt_q >= last_s) begin
                cnt_d  = CNT_ZERO;
                load_s = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else if (!dir_q) begin
            // Top of the triangle: P-1 is held for one extra cycle while turning.
            if (cnt_q >= last_s) begin
                dir_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            // Bottom of the triangle: down-0 -> up-0 is the period boundary.
            if (cnt_q == CNT_ZERO) begin
                dir_d  = 1'b0;
                load_s = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    // Active-copy load and compare/output next-state.
    always_comb begin
        period_act_d = load_s ? period_stg_q : period_act_q;
        for (int c = 0; c < CHANNELS; c++) begin
            duty_act_d[c] = load_s ? duty_stg_q[c] : duty_act_q[c];
            raw_s[c]      = (cnt_q < duty_act_q[c]);
        end
        if (active_s) begin
            pwm_d = raw_s ^ pol_q;
            ps_d  = (cnt_q == CNT_ZERO) && !dir_q;
        end else begin
            pwm_d = pol_q;
            ps_d  = 1'b0;
        end
    end

    // Reset release synchroniser: state starts updating one edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q         <= 1'b0;
            mode_q       <= 1'b0;
            pol_q        <= {CHANNELS{1'b0}};
            period_stg_q <= CNT_ZERO;
            period_act_q <= CNT_ZERO;
            duty_stg_q   <= '{default: CNT_ZERO};
            duty_act_q   <= '{default: CNT_ZERO};
            cnt_q        <= CNT_ZERO;
            dir_q        <= 1'b0;
            idle_q       <= 1'b1;
            pwm_q        <= {CHANNELS{1'b0}};
            ps_q         <= 1'b0;
        end else if (run_q) begin
            en_q         <= en_d;
            mode_q       <= mode_d;
            pol_q        <= pol_d;
            period_stg_q <= period_stg_d;
            period_act_q <= period_act_d;
            duty_stg_q   <= duty_stg_d;
            duty_act_q   <= duty_act_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            idle_q       <= idle_d;
            pwm_q        <= pwm_d;
            ps_q         <= ps_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Testbench for pwm_multi: table vectors, hand-written corner sequences and
// randomized programming checked against a phase-based reference model.
module tb_pwm_multi;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [31:0]   wr_data = '0;
    logic [CH-1:0] pwm_out;
    logic          period_start;

    pwm_multi #(.CHANNELS(CH), .WIDTH(W), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .pwm_out(pwm_out), .period_start(period_start)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int p; bit centre; int d0; bit pol0;   // inputs
        int hi; int len;                       // expected high cycles / period length
    } vec_t;
    vec_t tbl[10];

    // Reference model: position within the period plus staging/active copies.
    int          m_stg_p, m_act_p, m_snap_p;
    int          m_stg_d[CH], m_act_d[CH], m_snap_d[CH];
    bit          m_centre;
    bit [CH-1:0] m_pol;
    int          m_ph, m_len;
    bit          pend;
    int          pend_a;
    logic [31:0] pend_d;
    int          hi_cnt[CH];
    int          ps_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model_write(input int a, input logic [31:0] d);
        if (a == 0) begin
            m_stg_p = int'(d[W-1:0]);
        end else if (a == 1) begin
            m_centre = d[1];
            m_pol    = d[16 +: CH];
        end else if (a >= 2 && a < 2 + CH) begin
            m_stg_d[a-2] = int'(d[W-1:0]);
        end
    endfunction

    function automatic logic [CH-1:0] exp_out(input int ph);
        logic [CH-1:0] r;
        int cnt;
        cnt = (m_centre && ph >= m_act_p) ? (2 * m_act_p - 1 - ph) : ph;
        for (int c = 0; c < CH; c++) r[c] = (cnt < m_act_d[c]) ^ m_pol[c];
        return r;
    endfunction

    task automatic wr(input int a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        model_write(a, d);
        step();
        wr_en = 1'b0;
    endtask

    task automatic clr();
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        ps_cnt = 0;
    endtask

    // Called right after the EN=1 write: one inactive cycle, then period phase 0.
    task automatic start_run();
        step();
        check("enable_latency_pwm", 32'(pwm_out), 32'(m_pol));
        check("enable_latency_ps", 32'(period_start), 32'd0);
        step();
        m_act_p = m_stg_p;
        m_act_d = m_stg_d;
        m_ph    = 0;
        m_len   = m_centre ? 2 * m_act_p : m_act_p;
        pend    = 1'b0;
    endtask

    task automatic end_run();
        if (pend) model_write(pend_a, pend_d);
        pend = 1'b0;
    endtask

    // Compare one sample against the model, then optionally issue a write.
    task automatic cyc(input bit we, input int a, input logic [31:0] d);
        logic [CH-1:0] e;
        e = exp_out(m_ph);
        check("pwm_out", 32'(pwm_out), 32'(e));
        check("period_start", 32'(period_start), 32'(m_ph == 0));
        for (int c = 0; c < CH; c++) hi_cnt[c] += int'(pwm_out[c]);
        ps_cnt += int'(period_start);
        // The boundary edge loads whatever was staged before it.
        if (m_ph == m_len - 1) begin
            m_snap_p = m_stg_p;
            m_snap_d = m_stg_d;
        end
        if (pend) model_write(pend_a, pend_d);
        pend = we; pend_a = a; pend_d = d;
        m_ph++;
        if (m_ph == m_len) begin
            m_ph    = 0;
            m_act_p = m_snap_p;
            m_act_d = m_snap_d;
            m_len   = m_centre ? 2 * m_act_p : m_act_p;
        end
        wr_en = we; wr_addr = AW'(a); wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 0, 32'd0);
    endtask

    task automatic model_reset();
        m_stg_p = 0; m_act_p = 0; m_snap_p = 0;
        for (int c = 0; c < CH; c++) begin
            m_stg_d[c] = 0; m_act_d[c] = 0; m_snap_d[c] = 0;
        end
        m_centre = 1'b0; m_pol = '0; pend = 1'b0;
    endtask

    initial begin
        tbl[0] = '{10, 1'b0, 3,  1'b0, 3,  10};
        tbl[1] = '{10, 1'b0, 0,  1'b0, 0,  10};
        tbl[2] = '{10, 1'b0, 15, 1'b0, 10, 10};
        tbl[3] = '{10, 1'b0, 0,  1'b1, 10, 10};
        tbl[4] = '{10, 1'b0, 15, 1'b1, 0,  10};
        tbl[5] = '{8,  1'b1, 3,  1'b0, 6,  16};
        tbl[6] = '{1,  1'b0, 1,  1'b0, 1,  1};
        tbl[7] = '{1,  1'b0, 0,  1'b0, 0,  1};
        tbl[8] = '{5,  1'b1, 5,  1'b0, 10, 10};
        tbl[9] = '{6,  1'b1, 0,  1'b1, 12, 12};

        model_reset();
        clr();

        // Reset state.
        #3;
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_ps", 32'(period_start), 32'd0);
        #20 rst_n = 1'b1;
        step(); step(); step();
        check("post_reset_pwm", 32'(pwm_out), 32'd0);

        // Basic: P=10, DUTY0=3, DUTY1=7, DUTY2=1.
        wr(1, 32'd0); wr(0, 32'd10); wr(2, 32'd3); wr(3, 32'd7); wr(4, 32'd1); wr(5, 32'd0);
        wr(1, 32'd1);
        start_run();
        clr();
        idle_cyc(30);
        check("basic_hi0", 32'(hi_cnt[0]), 32'd9);
        check("basic_hi1", 32'(hi_cnt[1]), 32'd21);
        check("basic_ps_count", 32'(ps_cnt), 32'd3);

        // Shadowing: DUTY0=8 mid-period applies from the next period.
        idle_cyc(4);
        cyc(1'b1, 2, 32'd8);
        idle_cyc(5);
        clr();
        idle_cyc(10);
        check("shadow_duty_hi0", 32'(hi_cnt[0]), 32'd8);
        // Shadowing of PERIOD 10 -> 6 together with DUTY0=3.
        idle_cyc(4);
        cyc(1'b1, 0, 32'd6);
        cyc(1'b1, 2, 32'd3);
        idle_cyc(4);
        clr();
        idle_cyc(6);
        check("shadow_period_hi0", 32'(hi_cnt[0]), 32'd3);
        check("shadow_period_ps", 32'(ps_cnt), 32'd1);
        check("shadow_period_next_ps", 32'(period_start), 32'd1);

        // DUTY2 written in the boundary cycle: old value for one more period.
        idle_cyc(4);
        cyc(1'b1, 4, 32'd4);
        idle_cyc(1);
        clr();
        idle_cyc(6);
        check("boundary_old_hi2", 32'(hi_cnt[2]), 32'd1);
        clr();
        idle_cyc(6);
        check("boundary_new_hi2", 32'(hi_cnt[2]), 32'd4);
        end_run();

        // Asynchronous reset in the middle of a pulse.
        cyc(1'b0, 0, 32'd0);
        check("pulse_before_reset", 32'(pwm_out[0]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async_reset_pwm", 32'(pwm_out), 32'd0);
        check("async_reset_ps", 32'(period_start), 32'd0);
        #20 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            check("after_reset_pwm", 32'(pwm_out), 32'd0);
        end
        wr(1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("en_zero_period_pwm", 32'(pwm_out), 32'd0);
            check("en_zero_period_ps", 32'(period_start), 32'd0);
        end
        wr(0, 32'd4);
        step();
        start_run();
        idle_cyc(8);
        end_run();

        // Table-driven limits, polarity and mode vectors.
        for (int i = 0; i < 10; i++) begin
            wr(1, 32'd0);
            wr(0, 32'(tbl[i].p));
            wr(2, 32'(tbl[i].d0));
            wr(1, 32'd1 | (32'(tbl[i].centre) << 1) | (32'(tbl[i].pol0) << 16));
            start_run();
            clr();
            for (int k = 0; k < tbl[i].len; k++) cyc(1'b0, 0, 32'd0);
            end_run();
            check("tbl_hi0", 32'(hi_cnt[0]), 32'(tbl[i].hi));
            check("tbl_ps_count", 32'(ps_cnt), 32'd1);
            check("tbl_ps_period", 32'(period_start), 32'd1);
            wr(1, 32'(tbl[i].pol0) << 16);
            step();
            check("tbl_disabled_pwm0", 32'(pwm_out[0]), 32'(tbl[i].pol0));
            check("tbl_disabled_ps", 32'(period_start), 32'd0);
        end

        // Randomized programming with random mid-run writes.
        for (int r = 0; r < 8; r++) begin
            int p;
            logic [CH-1:0] pol;
            bit cen;
            p   = int'($urandom_range(1, 12));
            cen = 1'($urandom_range(0, 1));
            pol = CH'($urandom);
            wr(1, 32'd0);
            wr(0, {16'($urandom), 16'(p)});
            for (int c = 0; c < CH; c++)
                wr(2 + c, {16'($urandom), 16'($urandom_range(0, p + 2))});
            wr(1, 32'd1 | (32'(cen) << 1) | (32'(pol) << 16));
            start_run();
            for (int i = 0; i < 40; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    int kind;
                    kind = int'($urandom_range(0, 2));
                    if (kind == 0)
                        cyc(1'b1, 0, {16'($urandom), 16'($urandom_range(1, 12))});
                    else if (kind == 1)
                        cyc(1'b1, 2 + int'($urandom_range(0, CH - 1)), {16'($urandom), 16'($urandom_range(0, 14))});
                    else
                        cyc(1'b1, int'($urandom_range(2 + CH, 31)), $urandom);
                end else begin
                    cyc(1'b0, 0, 32'd0);
                end
            end
            end_run();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
